// File: rtl/frogger_pkg.sv
// Shared types and constants for the Frogger lane engine and game randomisers.
package frogger_pkg;

    typedef enum logic [1:0] {IDLE, CAR, GAP} lane_state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11), advancing once per cycle when adv is high.
module lfsr16
    import frogger_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        adv,
    output logic [15:0] q
);

    // An all-zero state would lock the register, so a zero seed is replaced.
    localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= SEED_NZ;
        end else if (adv) begin
            q <= q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
        end
    end

endmodule

// File: rtl/frogger_lane.sv
// Scrolling traffic lane: tick counter, LFSR-driven car spawner, shifter and frog collision flag.
module frogger_lane
    import frogger_pkg::*;
#(
    parameter int          WIDTH   = 16,
    parameter int          CNT_W   = 24,
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int          MIN_GAP = 2,
    parameter int          MAX_RUN = 3
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [CNT_W-1:0]         period,
    input  logic                     dir,
    input  logic [2:0]               density,
    input  logic [$clog2(WIDTH)-1:0] frog_col,
    input  logic                     frog_here,
    output logic [WIDTH-1:0]         lane,
    output logic                     step,
    output logic                     hit
);

    localparam int             COL_W   = $clog2(WIDTH);
    localparam int             GAP_W   = (MIN_GAP > 1) ? $clog2(MIN_GAP + 1) : 1;
    localparam logic [2:0]     MAX_LEN = 3'(MAX_RUN);
    localparam logic [GAP_W-1:0] GAP_LEN = GAP_W'(MIN_GAP);

    logic [CNT_W-1:0] cnt;
    logic             terminal;
    logic             do_step;
    logic [15:0]      lfsr_q;
    logic             unused_lfsr;

    lane_state_t      state, state_nxt;
    logic [1:0]       rem, rem_nxt;
    logic [GAP_W-1:0] gcnt, gcnt_nxt;
    logic [2:0]       run_len;
    logic             spawn;
    logic [WIDTH-1:0] lane_nxt;
    logic             lane_bit;
    logic             col_ok;

    assign terminal    = (period <= CNT_W'(1)) || (cnt >= period - CNT_W'(1));
    assign do_step     = enable & terminal;
    assign unused_lfsr = &{1'b0, lfsr_q[15:5]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= terminal ? '0 : cnt + CNT_W'(1);
        end
    end

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clock   (clock),
        .reset_n (reset_n),
        .adv     (do_step),
        .q       (lfsr_q)
    );

    // Spawn decisions read the LFSR value from before this step's advance.
    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        gcnt_nxt  = gcnt;
        spawn     = 1'b0;
        run_len   = 3'd1 + {1'b0, lfsr_q[4:3]};
        if (run_len > MAX_LEN) begin
            run_len = MAX_LEN;
        end
        case (state)
            IDLE: begin
                if (lfsr_q[2:0] < density) begin
                    spawn   = 1'b1;
                    rem_nxt = 2'(run_len - 3'd1);
                    if (run_len == 3'd1) begin
                        state_nxt = (MIN_GAP == 0) ? IDLE : GAP;
                        gcnt_nxt  = GAP_LEN;
                    end else begin
                        state_nxt = CAR;
                    end
                end
            end
            CAR: begin
                spawn   = 1'b1;
                rem_nxt = rem - 2'd1;
                if (rem <= 2'd1) begin
                    state_nxt = (MIN_GAP == 0) ? IDLE : GAP;
                    gcnt_nxt  = GAP_LEN;
                end
            end
            GAP: begin
                gcnt_nxt = gcnt - GAP_W'(1);
                if (gcnt <= GAP_W'(1)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign lane_nxt = dir ? {spawn, lane[WIDTH-1:1]} : {lane[WIDTH-2:0], spawn};

    always_comb begin
        lane_bit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (COL_W'(i) == frog_col) begin
                lane_bit = lane[i];
            end
        end
    end

    assign col_ok = ({1'b0, frog_col} < (COL_W + 1)'(WIDTH));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lane  <= '0;
            step  <= 1'b0;
            hit   <= 1'b0;
            state <= IDLE;
            rem   <= '0;
            gcnt  <= '0;
        end else begin
            step <= do_step;
            hit  <= frog_here & col_ok & lane_bit;
            if (do_step) begin
                lane  <= lane_nxt;
                state <= state_nxt;
                rem   <= rem_nxt;
                gcnt  <= gcnt_nxt;
            end
        end
    end

endmodule

// File: tb/tb_frogger_lane.sv
// Scoreboard bench for frogger_lane: expected lanes are queued by stimulus and popped on each step pulse.
module tb_frogger_lane;

    localparam int W  = 16;
    localparam int CW = 24;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [CW-1:0] period;
    logic          dir;
    logic [2:0]    density;
    logic [3:0]    frog_col;
    logic          frog_here;
    logic [W-1:0]  lane;
    logic          step;
    logic          hit;

    logic [3:0]    frog_col12 = 4'd13;
    logic [11:0]   lane12;
    logic          step12;
    logic          hit12;

    int            tests_run    = 0;
    int            tests_failed = 0;
    int            step_count   = 0;
    logic [15:0]   exp_q[$];

    bit            rl_on    = 1'b0;
    bit            seen_car = 1'b0;
    int            one_run  = 0;
    int            zero_run = 0;

    logic [15:0]   m_lfsr;
    logic [15:0]   m_lane;
    int            m_st;
    int            m_rem;
    int            m_gcnt;

    always #5 clock = ~clock;

    frogger_lane #(.WIDTH(W), .CNT_W(CW), .SEED(16'hACE1), .MIN_GAP(2), .MAX_RUN(3)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .period    (period),
        .dir       (dir),
        .density   (density),
        .frog_col  (frog_col),
        .frog_here (frog_here),
        .lane      (lane),
        .step      (step),
        .hit       (hit)
    );

    frogger_lane #(.WIDTH(12), .CNT_W(CW), .SEED(16'hACE1), .MIN_GAP(2), .MAX_RUN(3)) dut12 (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (1'b1),
        .period    (24'd0),
        .dir       (1'b0),
        .density   (3'd7),
        .frog_col  (frog_col12),
        .frog_here (1'b1),
        .lane      (lane12),
        .step      (step12),
        .hit       (hit12)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [CW-1:0] per, input logic d, input logic [2:0] dens);
        enable  = en;
        period  = per;
        dir     = d;
        density = dens;
    endtask

    function automatic void model_reset();
        m_lfsr = 16'hACE1;
        m_lane = '0;
        m_st   = 0;
        m_rem  = 0;
        m_gcnt = 0;
    endfunction

    // Reference lane model: 0 = idle, 1 = car, 2 = gap; MIN_GAP=2, MAX_RUN=3.
    function automatic logic [15:0] model_step(input logic d, input int dens);
        logic s;
        int   len;
        s = 1'b0;
        case (m_st)
            0: begin
                if (int'(m_lfsr[2:0]) < dens) begin
                    s     = 1'b1;
                    len   = 1 + int'(m_lfsr[4:3]);
                    if (len > 3) len = 3;
                    m_rem = len - 1;
                    if (m_rem == 0) begin
                        m_st   = 2;
                        m_gcnt = 2;
                    end else begin
                        m_st = 1;
                    end
                end
            end
            1: begin
                s = 1'b1;
                m_rem--;
                if (m_rem == 0) begin
                    m_st   = 2;
                    m_gcnt = 2;
                end
            end
            default: begin
                m_gcnt--;
                if (m_gcnt == 0) m_st = 0;
            end
        endcase
        m_lane = d ? {s, m_lane[15:1]} : {m_lane[14:0], s};
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        return m_lane;
    endfunction

    // Monitor: pops one expected lane per step pulse and tracks run lengths entering at cell 0.
    always @(posedge clock) begin
        #1;
        if (reset_n && step) begin
            step_count++;
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected step: lane 0x%0h, no expected entry queued", lane);
            end else begin
                checkOutput("lane at step", 32'(lane), 32'(exp_q.pop_front()));
            end
            if (rl_on) begin
                if (lane[0]) begin
                    if (zero_run > 0 && seen_car) checkOutput("min gap >= 2", 32'(zero_run >= 2), 32'd1);
                    zero_run = 0;
                    one_run++;
                    seen_car = 1'b1;
                end else begin
                    if (one_run > 0) checkOutput("max run <= 3", 32'(one_run <= 3), 32'd1);
                    one_run = 0;
                    zero_run++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sc;
        reset_n   = 1'b0;
        frog_col  = 4'd0;
        frog_here = 1'b0;
        applyStimulus(1'b0, 24'd4, 1'b0, 3'd0);
        #1;
        checkOutput("reset lane", 32'(lane), 32'd0);
        checkOutput("reset step", 32'(step), 32'd0);
        checkOutput("reset hit", 32'(hit), 32'd0);

        // Cadence: density 0 keeps the lane empty.
        for (int i = 0; i < 30; i++) exp_q.push_back(16'h0000);
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;
        applyStimulus(1'b1, 24'd4, 1'b0, 3'd0);
        sc = step_count;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clock);
            #2;
            checkOutput($sformatf("step cadence p4 e%0d", e), 32'(step), 32'((e % 4) == 0));
        end
        checkOutput("steps in 40 cycles p4", 32'(step_count - sc), 32'd10);
        applyStimulus(1'b1, 24'd0, 1'b0, 3'd0);
        sc = step_count;
        for (int e = 41; e <= 60; e++) begin
            @(posedge clock);
            #2;
            checkOutput($sformatf("step every cycle p0 e%0d", e), 32'(step), 32'd1);
        end
        checkOutput("steps in 20 cycles p0", 32'(step_count - sc), 32'd20);
        checkOutput("lane empty at density 0", 32'(lane), 32'd0);
        applyStimulus(1'b0, 24'd4, 1'b0, 3'd0);
        reset_n = 1'b0;
        checkOutput("queue drained after cadence", 32'(exp_q.size()), 32'd0);

        // Directed spawn sequence from the seed, direction flip after the ninth step.
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0002);
        exp_q.push_back(16'h0004);
        exp_q.push_back(16'h0009);
        exp_q.push_back(16'h0013);
        exp_q.push_back(16'h0027);
        exp_q.push_back(16'h004E);
        exp_q.push_back(16'h009C);
        exp_q.push_back(16'h0139);
        exp_q.push_back(16'h009C);
        frog_col  = 4'd5;
        frog_here = 1'b1;
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;
        applyStimulus(1'b1, 24'd4, 1'b0, 3'd7);
        sc = step_count;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clock);
            #2;
            if (e == 24) checkOutput("hit before car at col 5", 32'(hit), 32'd0);
            if (e == 25) checkOutput("hit 1 cycle after car at col 5", 32'(hit), 32'd1);
            if (e == 33) frog_here = 1'b0;
            if (e == 36) dir = 1'b1;
            if (e == 37) begin
                checkOutput("hit with frog absent", 32'(hit), 32'd0);
                frog_here = 1'b1;
            end
            if (e == 38) checkOutput("hit after frog returns", 32'(hit), 32'd1);
            if (e == 39) checkOutput("cells 3..5 before flip", 32'(lane), 32'h0139);
        end
        checkOutput("lane after dir flip", 32'(lane), 32'h009C);
        checkOutput("steps in directed run", 32'(step_count - sc), 32'd10);

        // Freeze with cnt=2; the held step lands two cycles after re-enable.
        exp_q.push_back(16'h004E);
        frog_col = 4'd2;
        sc = step_count;
        repeat (2) @(posedge clock);
        #2;
        enable = 1'b0;
        repeat (10) @(posedge clock);
        #2;
        checkOutput("no step while frozen", 32'(step_count - sc), 32'd0);
        checkOutput("lane held while frozen", 32'(lane), 32'h009C);
        enable = 1'b1;
        @(posedge clock);
        #2;
        checkOutput("no step 1 cycle after re-enable", 32'(step), 32'd0);
        @(posedge clock);
        #2;
        checkOutput("step 2 cycles after re-enable", 32'(step), 32'd1);
        checkOutput("hit at col 2", 32'(hit), 32'd1);

        // Asynchronous reset while lane, step and hit are all set.
        reset_n = 1'b0;
        #1;
        checkOutput("async reset lane", 32'(lane), 32'd0);
        checkOutput("async reset step", 32'(step), 32'd0);
        checkOutput("async reset hit", 32'(hit), 32'd0);
        checkOutput("queue drained before long run", 32'(exp_q.size()), 32'd0);

        // Long run against the reference model with run-length rules.
        model_reset();
        for (int i = 0; i < 500; i++) exp_q.push_back(model_step(1'b0, 7));
        frog_here = 1'b0;
        applyStimulus(1'b1, 24'd4, 1'b0, 3'd7);
        rl_on = 1'b1;
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;
        sc = step_count;
        for (int e = 1; e <= 503; e++) begin
            @(posedge clock);
            #2;
            if (e == 3) checkOutput("no step before period edges", 32'(step_count - sc), 32'd0);
            if (e == 4) begin
                checkOutput("first step after reset release", 32'(step_count - sc), 32'd1);
                checkOutput("first lane after reset", 32'(lane), 32'h0001);
                period = 24'd1;
            end
            if ((e % 100) == 0) checkOutput("width 12 off-lane column hit", 32'(hit12), 32'd0);
        end
        checkOutput("steps in long run", 32'(step_count - sc), 32'd500);
        checkOutput("queue drained after long run", 32'(exp_q.size()), 32'd0);
        rl_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/frogger_lane.md
# frogger_lane

Parametrised traffic-lane engine for the Frogger LED-matrix display. The lane is a WIDTH-cell row of occupancy bits that scrolls one cell per programmable tick period in a selectable direction. New cars enter at the upstream edge, spawned by an LFSR under density, run-length and minimum-gap rules. The block also reports a registered collision flag for the frog's column. One instance drives each road/river row under the game top, replacing the fixed single-lane logic.

## Interface
- WIDTH, 16, number of cells in the lane (≥2)
- CNT_W, 24, width of the tick-period counter
- SEED, 16'hACE1, LFSR reset value (0 is replaced by 16'h0001)
- MIN_GAP, 2, minimum empty cells between cars (0 allowed)
- MAX_RUN, 3, maximum car length in cells (1..4)

- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  1 = lane advances; 0 = freeze scrolling
- period  in  CNT_W  clock cycles per step; 0 and 1 both mean every cycle
- dir  in  1  0 = cars move toward higher index (enter at 0); 1 = toward lower index (enter at WIDTH-1)
- density  in  3  spawn threshold; 0 = never spawn, 7 = 7/8 probability per idle step
- frog_col  in  $clog2(WIDTH)  frog column
- frog_here  in  1  frog currently on this lane's row
- lane  out  WIDTH  registered occupancy, 1 = car
- step  out  1  one-cycle pulse, coincident with each lane update
- hit  out  1  registered collision flag

## Operation
- Tick counter cnt: when enable=1, increments each cycle. When cnt ≥ period-1 (or period ≤ 1), the next edge clears cnt and performs a step. When enable=0, cnt holds.
- Step, all in one edge:
  - lane shifts one cell in direction dir.
  - The vacated entry cell receives the spawn bit s.
  - LFSR advances once.
  - Spawn FSM updates.
  - step=1 for that cycle.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. Spawn decisions use the pre-advance value L.
- Spawn FSM, evaluated only on steps:
  - IDLE: if L[2:0] < density, then s=1 and len = min(1+L[4:3], MAX_RUN), with rem = len-1. If rem=0, go to GAP (or IDLE when MIN_GAP=0); otherwise go to CAR. If no spawn, s=0 and stay in IDLE.
  - CAR: s=1 and rem decrements. When rem reaches 0, go to GAP with gcnt=MIN_GAP (or IDLE when MIN_GAP=0).
  - GAP: s=0 and gcnt decrements. When gcnt reaches 0, go to IDLE.
- Guarantees: every run of 1s entering the lane is between 1 and MAX_RUN long; every run of 0s between cars is at least MIN_GAP long.
- dir change: takes effect at the next step. Cells already in the lane reverse direction. The FSM is not reset.
- hit: each cycle, hit <= frog_here & (frog_col < WIDTH) & lane[frog_col], sampling the registered lane. It is evaluated regardless of enable.
- Changes to period while running: compared on the next cycle. If cnt already ≥ the new period-1, a step occurs on the next edge.

## Timing
- Reset (asynchronous, immediate): lane=0, step=0, hit=0, cnt=0, LFSR=SEED, FSM=IDLE, rem=0, gcnt=0.
- After reset release with enable=1, the first step occurs on the period-th rising edge. Steps then repeat every max(period,1) cycles.
- hit has 1-cycle latency from a lane, frog_col or frog_here change.
- A mid-step reset discards the step completely. No partial shift is visible.
- enable low on the terminal-count cycle suppresses that step. The step occurs on the first enabled cycle afterwards.

## Structure
- frogger_pkg holds:
  - typedef enum logic [1:0] {IDLE, CAR, GAP} lane_state_t
  - LFSR_TAPS = 16'hB400
- Sub-module lfsr16 (clock, reset_n, adv, seed parameter, q[15:0]). It is reusable by the other game randomisers.
- All remaining logic (counter, shifter, FSM, hit register) lives in frogger_lane.

## Test plan
- Reset mid-operation: drive reset_n=0 at an arbitrary time while lane is non-zero. lane=0, step=0 and hit=0 without waiting for a clock edge. After release, the first step comes exactly period edges later.
- Cadence: period=4, enable=1, density=0. step is high one cycle in every 4 over 40 cycles, and lane stays 0. With period=0, step is high every cycle.
- Spawn rules: density=7, dir=0, WIDTH=16, MIN_GAP=2, MAX_RUN=3, run 500 steps. A scoreboard of lane[0] per step shows no run of 1s longer than 3, no run of 0s between cars shorter than 2, and exact match with a reference LFSR/FSM model.
- Direction flip:
  - After cells 3..5 are occupied with dir=0, set dir=1. After the next step, cells 2..4 are occupied and the new bit enters at cell 15.
- Collision:
  - frog_col=5, frog_here=1, lane[5] goes 0→1: hit rises exactly 1 cycle later.
  - frog_here=0: hit=0.
  - WIDTH=12 with frog_col=13: hit=0.
- Freeze: enable=0 for 10 cycles at cnt=2, period=4. There is no step and lane is unchanged. After re-enable, the step occurs 2 cycles later.
